// File: rtl/tx_ctrl_pkg.sv
// tx_ctrl_pkg: shared types and constants for the tx_core control slice.
//   - tx_state_t        : sweep sequencer state encoding
//   - TX_PHASE_W        : width of the tx_core LO DDS phase increment
//   - TX_SETTLE_DEFAULT : cycles from a phase_inc change to a settled DAC tone
//   - OSEL_*            : tx_core output_select codes
package tx_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DWELL  = 2'd2
    } tx_state_t;

    localparam int unsigned TX_PHASE_W        = 16;
    localparam int unsigned TX_SETTLE_DEFAULT = 8;

    localparam logic [4:0] OSEL_ADC1     = 5'd1;
    localparam logic [4:0] OSEL_ADC2     = 5'd2;
    localparam logic [4:0] OSEL_ADC3     = 5'd3;
    localparam logic [4:0] OSEL_SIN_MULT = 5'd4;
    localparam logic [4:0] OSEL_COS_MULT = 5'd5;
    localparam logic [4:0] OSEL_ADD1     = 5'd6;
    localparam logic [4:0] OSEL_ADD2     = 5'd7;

endpackage

// File: rtl/tx_down_counter.sv
// tx_down_counter: loadable down-counter that stops at zero.
//   clock      : system clock
//   resetn     : asynchronous active-low reset (count -> 0)
//   load       : load load_value this cycle (has priority over counting)
//   load_value : value to load
//   count      : current count
//   zero       : count == 0
module tx_down_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/tx_lo_sweep_ctrl.sv
// tx_lo_sweep_ctrl: steps the tx_core LO DDS phase increment from a start to a
// stop value, holding each tone for a programmed dwell and flagging dac_valid
// only once the tx_core datapath has settled on the tone.
//   clock, resetn      : system clock, asynchronous active-low reset
//   cfg_*              : sweep configuration, captured on start
//   start, abort       : single-cycle control pulses (abort wins)
//   lo_dds_phase_inc   : phase increment to tx_core
//   output_select      : output select to tx_core
//   dac_valid          : DAC data is on a settled tone
//   busy               : sweep in progress
//   sweep_done         : one-cycle pulse at end of a single-pass sweep
//   step_index         : 0-based index of the current tone (saturating)
module tx_lo_sweep_ctrl
    import tx_ctrl_pkg::*;
#(
    parameter int unsigned PHASE_W       = TX_PHASE_W,
    parameter int unsigned DWELL_W       = 24,
    parameter int unsigned SETTLE_CYCLES = TX_SETTLE_DEFAULT
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [PHASE_W-1:0] cfg_start_inc,
    input  logic [PHASE_W-1:0] cfg_stop_inc,
    input  logic [PHASE_W-1:0] cfg_step_inc,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_continuous,
    input  logic [4:0]         cfg_output_select,
    input  logic               start,
    input  logic               abort,
    output logic [PHASE_W-1:0] lo_dds_phase_inc,
    output logic [4:0]         output_select,
    output logic               dac_valid,
    output logic               busy,
    output logic               sweep_done,
    output logic [15:0]        step_index
);

    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    tx_state_t state;

    logic [PHASE_W-1:0] sh_start;
    logic [PHASE_W-1:0] sh_stop;
    logic [PHASE_W-1:0] sh_step;
    logic [DWELL_W-1:0] sh_dwell;
    logic               sh_cont;

    logic               settle_load;
    logic               dwell_load;
    logic [SET_W-1:0]   settle_count;
    logic               settle_zero;
    logic [DWELL_W-1:0] dwell_value;
    logic [DWELL_W-1:0] dwell_count;
    logic               dwell_zero;

    logic               sweep_end;
    logic [PHASE_W:0]   next_sum;
    logic [PHASE_W-1:0] next_inc;

    // Last tone reached: stop hit, zero step, or an empty/inverted range.
    assign sweep_end = (lo_dds_phase_inc >= sh_stop) || (sh_step == '0) ||
                       (sh_start >= sh_stop);

    // One extra bit so the clamp to stop catches what would otherwise wrap.
    assign next_sum = {1'b0, lo_dds_phase_inc} + {1'b0, sh_step};
    assign next_inc = (next_sum > {1'b0, sh_stop}) ? sh_stop : next_sum[PHASE_W-1:0];

    assign dwell_value = (sh_dwell == '0) ? '0 : sh_dwell - 1'b1;

    always_comb begin
        settle_load = 1'b0;
        dwell_load  = 1'b0;
        case (state)
            IDLE:    settle_load = start && !abort;
            SETTLE:  dwell_load  = !abort && settle_zero;
            DWELL:   settle_load = !abort && dwell_zero && (!sweep_end || sh_cont);
            default: ;
        endcase
    end

    tx_down_counter #(.WIDTH(SET_W)) u_settle_cnt (
        .clock      (clock),
        .resetn     (resetn),
        .load       (settle_load),
        .load_value (SET_W'(SETTLE_CYCLES - 1)),
        .count      (settle_count),
        .zero       (settle_zero)
    );

    tx_down_counter #(.WIDTH(DWELL_W)) u_dwell_cnt (
        .clock      (clock),
        .resetn     (resetn),
        .load       (dwell_load),
        .load_value (dwell_value),
        .count      (dwell_count),
        .zero       (dwell_zero)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state            <= IDLE;
            sh_start         <= '0;
            sh_stop          <= '0;
            sh_step          <= '0;
            sh_dwell         <= '0;
            sh_cont          <= 1'b0;
            lo_dds_phase_inc <= '0;
            output_select    <= '0;
            dac_valid        <= 1'b0;
            busy             <= 1'b0;
            sweep_done       <= 1'b0;
            step_index       <= '0;
        end else begin
            sweep_done <= 1'b0;
            if (abort) begin
                // Phase, select and index hold so tx_core keeps its last tone.
                state     <= IDLE;
                dac_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            sh_start         <= cfg_start_inc;
                            sh_stop          <= cfg_stop_inc;
                            sh_step          <= cfg_step_inc;
                            sh_dwell         <= cfg_dwell;
                            sh_cont          <= cfg_continuous;
                            lo_dds_phase_inc <= cfg_start_inc;
                            output_select    <= cfg_output_select;
                            step_index       <= '0;
                            busy             <= 1'b1;
                            state            <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        if (settle_zero) begin
                            dac_valid <= 1'b1;
                            state     <= DWELL;
                        end
                    end
                    DWELL: begin
                        if (dwell_zero) begin
                            dac_valid <= 1'b0;
                            if (!sweep_end) begin
                                lo_dds_phase_inc <= next_inc;
                                if (step_index != 16'hFFFF) begin
                                    step_index <= step_index + 16'd1;
                                end
                                state <= SETTLE;
                            end else if (sh_cont) begin
                                lo_dds_phase_inc <= sh_start;
                                step_index       <= '0;
                                state            <= SETTLE;
                            end else begin
                                busy       <= 1'b0;
                                sweep_done <= 1'b1;
                                state      <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tx_lo_sweep_ctrl.sv
// Self-checking bench for tx_lo_sweep_ctrl (default parameters, SETTLE=8).
module tb_tx_lo_sweep_ctrl;

    localparam int SETTLE = 8;

    logic        clock = 1'b0;
    logic        resetn;
    logic [15:0] cfg_start_inc, cfg_stop_inc, cfg_step_inc;
    logic [23:0] cfg_dwell;
    logic        cfg_continuous;
    logic [4:0]  cfg_output_select;
    logic        start, abort;
    logic [15:0] lo_dds_phase_inc;
    logic [4:0]  output_select;
    logic        dac_valid, busy, sweep_done;
    logic [15:0] step_index;

    tx_lo_sweep_ctrl dut (
        .clock             (clock),
        .resetn            (resetn),
        .cfg_start_inc     (cfg_start_inc),
        .cfg_stop_inc      (cfg_stop_inc),
        .cfg_step_inc      (cfg_step_inc),
        .cfg_dwell         (cfg_dwell),
        .cfg_continuous    (cfg_continuous),
        .cfg_output_select (cfg_output_select),
        .start             (start),
        .abort             (abort),
        .lo_dds_phase_inc  (lo_dds_phase_inc),
        .output_select     (output_select),
        .dac_valid         (dac_valid),
        .busy              (busy),
        .sweep_done        (sweep_done),
        .step_index        (step_index)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0]      st, sp, stp;
        logic [23:0]      dw;
        logic [4:0]       osel;
        bit               poke;
        int               n;
        logic [5:0][15:0] tones;
    } vec_t;

    typedef struct {
        logic [15:0] ph;
        logic [15:0] idx;
        int          hi;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;
    int   done_cnt = 0;
    logic [4:0] cur_osel;

    always @(negedge clock) if (sweep_done === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    function automatic vec_t mk(input logic [15:0] st, sp, stp, input logic [23:0] dw,
                                input logic [4:0] osel, input bit poke, input int n,
                                input logic [15:0] t0, t1, t2, t3);
        vec_t v;
        v.st = st; v.sp = sp; v.stp = stp; v.dw = dw; v.osel = osel; v.poke = poke;
        v.n = n;
        v.tones = '0;
        v.tones[0] = t0; v.tones[1] = t1; v.tones[2] = t2; v.tones[3] = t3;
        return v;
    endfunction

    task automatic set_cfg(input logic [15:0] st, sp, stp, input logic [23:0] dw,
                           input logic cont, input logic [4:0] osel);
        cfg_start_inc = st; cfg_stop_inc = sp; cfg_step_inc = stp;
        cfg_dwell = dw; cfg_continuous = cont; cfg_output_select = osel;
    endtask

    task automatic scramble_cfg();
        set_cfg(16'($urandom), 16'($urandom), 16'($urandom), 24'($urandom_range(0, 5)),
                1'($urandom), 5'($urandom));
    endtask

    // Pops one expected tone: checks settle length, tone value/index and dwell length.
    task automatic do_tone(input int abort_at, input bit poke, output bit aborted);
        exp_t e;
        int lowcnt, hicnt;
        aborted = 1'b0;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        lowcnt = 0;
        while (dac_valid !== 1'b1 && lowcnt < 100) begin
            lowcnt++;
            tick();
        end
        chk("settle_len", lowcnt, SETTLE);
        chk("tone_phase", lo_dds_phase_inc, e.ph);
        chk("tone_index", step_index, e.idx);
        chk("tone_osel", output_select, cur_osel);
        chk("tone_busy", busy, 1);
        hicnt = 0;
        while (dac_valid === 1'b1 && hicnt < 1000) begin
            if (hicnt == abort_at) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                chk("abort_dac_valid", dac_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_phase_hold", lo_dds_phase_inc, e.ph);
                chk("abort_index_hold", step_index, e.idx);
                chk("abort_no_done", sweep_done, 0);
                aborted = 1'b1;
                return;
            end
            if (poke && hicnt == 1) start = 1'b1;
            hicnt++;
            tick();
            start = 1'b0;
        end
        chk("dwell_len", hicnt, e.hi);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   base;
        bit   ab;
        set_cfg(v.st, v.sp, v.stp, v.dw, 1'b0, v.osel);
        cur_osel = v.osel;
        base = done_cnt;
        for (int i = 0; i < v.n; i++) begin
            e.ph  = v.tones[i];
            e.idx = 16'(i);
            e.hi  = (v.dw == 0) ? 1 : int'(v.dw);
            sb.push_back(e);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        scramble_cfg();
        chk("start_phase", lo_dds_phase_inc, v.tones[0]);
        chk("start_busy", busy, 1);
        chk("start_index", step_index, 0);
        for (int i = 0; i < v.n; i++) do_tone(-1, v.poke && i == 1, ab);
        chk("done_pulse", sweep_done, 1);
        chk("done_busy", busy, 0);
        chk("done_dac_valid", dac_valid, 0);
        chk("done_phase_hold", lo_dds_phase_inc, v.tones[v.n-1]);
        tick();
        chk("done_one_cycle", sweep_done, 0);
        chk("done_count", done_cnt - base, 1);
        chk("sb_empty", sb.size(), 0);
        repeat (3) tick();
    endtask

    vec_t vecs[6];

    initial begin
        exp_t e;
        bit   ab;
        int   base;

        vecs[0] = mk(16'd100, 16'd130, 16'd10, 24'd4, 5'd4, 1'b1, 4, 16'd100, 16'd110, 16'd120, 16'd130);
        vecs[1] = mk(16'd100, 16'd125, 16'd10, 24'd4, 5'd6, 1'b0, 4, 16'd100, 16'd110, 16'd120, 16'd125);
        vecs[2] = mk(16'd77,  16'd200, 16'd0,  24'd0, 5'd1, 1'b0, 1, 16'd77, 16'd0, 16'd0, 16'd0);
        vecs[3] = mk(16'd50,  16'd40,  16'd5,  24'd3, 5'd2, 1'b0, 1, 16'd50, 16'd0, 16'd0, 16'd0);
        vecs[4] = mk(16'd60,  16'd60,  16'd3,  24'd2, 5'd7, 1'b0, 1, 16'd60, 16'd0, 16'd0, 16'd0);
        vecs[5] = mk(16'hFFF0, 16'hFFFF, 16'h0010, 24'd2, 5'd5, 1'b0, 2, 16'hFFF0, 16'hFFFF, 16'd0, 16'd0);

        resetn = 1'b0; start = 1'b0; abort = 1'b0;
        set_cfg('0, '0, '0, '0, 1'b0, '0);
        cur_osel = '0;
        repeat (2) tick();
        chk("rst_phase", lo_dds_phase_inc, 0);
        chk("rst_osel", output_select, 0);
        chk("rst_dac_valid", dac_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", sweep_done, 0);
        chk("rst_index", step_index, 0);
        resetn = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Continuous sweep, aborted on the second visit to tone 20.
        set_cfg(16'd10, 16'd30, 16'd10, 24'd3, 1'b1, 5'd3);
        cur_osel = 5'd3;
        base = done_cnt;
        e.hi = 3;
        e.ph = 16'd10; e.idx = 16'd0; sb.push_back(e);
        e.ph = 16'd20; e.idx = 16'd1; sb.push_back(e);
        e.ph = 16'd30; e.idx = 16'd2; sb.push_back(e);
        e.ph = 16'd10; e.idx = 16'd0; sb.push_back(e);
        e.ph = 16'd20; e.idx = 16'd1; sb.push_back(e);
        start = 1'b1;
        tick();
        start = 1'b0;
        scramble_cfg();
        for (int i = 0; i < 4; i++) do_tone(-1, 1'b0, ab);
        do_tone(1, 1'b0, ab);
        chk("cont_aborted", ab, 1);
        chk("cont_no_done", done_cnt - base, 0);
        repeat (SETTLE + 4) tick();
        chk("post_abort_idle", busy, 0);
        chk("post_abort_dac", dac_valid, 0);

        // start and abort together: abort wins.
        set_cfg(16'd999, 16'd1999, 16'd1, 24'd1, 1'b0, 5'd1);
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("contend_busy", busy, 0);
        chk("contend_phase_hold", lo_dds_phase_inc, 20);
        repeat (SETTLE + 3) tick();
        chk("contend_dac", dac_valid, 0);
        chk("contend_still_idle", busy, 0);

        // Asynchronous reset mid-SETTLE.
        set_cfg(16'd300, 16'd400, 16'd50, 24'd2, 1'b0, 5'd6);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("pre_rst_busy", busy, 1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_phase", lo_dds_phase_inc, 0);
        chk("arst_osel", output_select, 0);
        chk("arst_busy", busy, 0);
        chk("arst_dac", dac_valid, 0);
        chk("arst_done", sweep_done, 0);
        chk("arst_index", step_index, 0);
        repeat (2) tick();
        resetn = 1'b1;
        repeat (20) tick();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_dac", dac_valid, 0);
        chk("post_rst_phase", lo_dds_phase_inc, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
